// File: rtl/ws2812b_strip_ctrl.sv
// ws2812b_strip_ctrl
// Frame sequencer placed in front of the single-pixel WS2812B serializer.
// It holds a pixel buffer for the whole chain. On a start request it hands the
// serializer one pixel per fixed-length slot: a one-cycle o_send pulse, with the
// colour held stable on o_red/o_green/o_blue. After the last slot it keeps the
// line idle for the latch gap and then pulses o_done. The serializer gives no
// busy/done feedback, so all pacing is done by counting cycles.
//
// Ports:
//   i_clk       system clock, rising edge
//   i_rst       synchronous reset, active-high
//   i_wr_en     pixel buffer write strobe
//   i_wr_addr   pixel index to write (ignored when >= NUM_LEDS)
//   i_wr_data   pixel colour {red, green, blue}
//   i_start     frame start request (ignored while busy)
//   o_send      one-cycle pulse to the serializer's i_send
//   o_red/o_green/o_blue  colour to the serializer, held between sends
//   o_busy      high while a frame is in progress
//   o_done      one-cycle pulse at frame end
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for i_start
// S_READ  | first pixel read; colour register loads from the buffer
// S_SEND  | o_send high, slot counter = 1
// S_WAIT  | slot counter runs up to SLOT_CYCLES; the next pixel's read is
//         | folded into the last WAIT cycle
// S_LATCH | line idle for RESET_CYCLES cycles
// S_DONE  | o_done pulse, then back to idle

module ws2812b_strip_ctrl #(
  parameter int NUM_LEDS     = 8,
  parameter int ADDR_W       = 3,
  parameter int SLOT_CYCLES  = 860,
  parameter int RESET_CYCLES = 2000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [23:0]       i_wr_data,
  input  logic              i_start,
  output logic              o_send,
  output logic [7:0]        o_red,
  output logic [7:0]        o_green,
  output logic [7:0]        o_blue,
  output logic              o_busy,
  output logic              o_done
);

  localparam int CNT_MAX = (SLOT_CYCLES > RESET_CYCLES) ? SLOT_CYCLES : RESET_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int MEM_AW  = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_LEDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_SEND,
    S_WAIT,
    S_LATCH,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]  slot_cnt;
  logic [CNT_W-1:0]  rst_cnt;
  logic [ADDR_W-1:0] idx;
  logic [23:0]       colour;
  logic [23:0]       pix_mem [2**MEM_AW];

  logic              slot_end;
  logic              latch_end;
  logic              adv;
  logic              load;
  logic [MEM_AW-1:0] rd_idx;
  logic              wr_ok;

  assign slot_end  = (slot_cnt == CNT_W'(SLOT_CYCLES));
  assign latch_end = (rst_cnt == CNT_W'(RESET_CYCLES));
  // Advancing to the next pixel happens straight from the last WAIT cycle so
  // that send pulses stay exactly SLOT_CYCLES apart.
  assign adv    = (state == S_WAIT) && slot_end && (idx != LAST_IDX);
  assign load   = (state == S_READ) || adv;
  assign rd_idx = (state == S_WAIT) ? MEM_AW'(idx + 1'b1) : MEM_AW'(idx);
  assign wr_ok  = i_wr_en && ({1'b0, i_wr_addr} < (ADDR_W + 1)'(NUM_LEDS));

  // Pixel buffer: no reset, contents survive i_rst. Read-during-write to the
  // same index returns the old word because both sides are registered.
  always_ff @(posedge i_clk) begin
    if (wr_ok) pix_mem[MEM_AW'(i_wr_addr)] <= i_wr_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (i_start) state_nxt = S_READ;
      S_READ:  state_nxt = S_SEND;
      S_SEND:  state_nxt = S_WAIT;
      S_WAIT:  if (slot_end) state_nxt = (idx == LAST_IDX) ? S_LATCH : S_SEND;
      S_LATCH: if (latch_end) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_send = (state == S_SEND);
    o_busy = (state != S_IDLE);
    o_done = (state == S_DONE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      slot_cnt <= '0;
      rst_cnt  <= '0;
      idx      <= '0;
      colour   <= '0;
    end else begin
      if (state == S_IDLE && i_start) idx <= '0;
      else if (adv)                   idx <= idx + 1'b1;

      // Colour register doubles as the RAM output register, so the pixel is
      // valid during the SEND cycle together with o_send.
      if (load) colour <= pix_mem[rd_idx];

      if (load)                                   slot_cnt <= CNT_W'(1);
      else if (state == S_SEND || state == S_WAIT) slot_cnt <= slot_cnt + 1'b1;
      else                                        slot_cnt <= '0;

      if (state == S_WAIT && slot_end && idx == LAST_IDX) rst_cnt <= CNT_W'(1);
      else if (state == S_LATCH)                          rst_cnt <= rst_cnt + 1'b1;
      else                                                rst_cnt <= '0;
    end
  end

  assign o_red   = colour[23:16];
  assign o_green = colour[15:8];
  assign o_blue  = colour[7:0];

endmodule
